// File: rtl/pcm_tx_pkg.sv
// Shared types and sizing helpers for the PCM serial transmitter.
package pcm_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } tx_state_t;

    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned frame_len(input int unsigned clk_div, input int unsigned data_w);
        return 2 * clk_div * data_w;
    endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// Small synchronous FIFO with combinational head output; a push while full is
// accepted when a pop happens in the same cycle.
module pcm_sync_fifo
    import pcm_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pcm_serial_tx.sv
// Buffers PCM samples in a FIFO and serialises them MSB-first on a master-mode
// frame-select / bit-clock / data interface with a sticky overflow flag.
module pcm_serial_tx
    import pcm_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV    = 8,
    parameter int unsigned GAP_CYC    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_W-1:0]                pcm_in,
    input  logic                             pcm_valid,
    input  logic                             ovf_clr,
    output logic                             sclk_out,
    output logic                             fs_out,
    output logic                             sdata_out,
    output logic                             ovf_flag,
    output logic [level_w(FIFO_DEPTH)-1:0]   fifo_level
);

    localparam int unsigned HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BC_W = $clog2(DATA_W);
    localparam int unsigned GC_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_CYC - 1);

    tx_state_t         state;
    logic [HC_W-1:0]   hcnt;
    logic [BC_W-1:0]   bcnt;
    logic [GC_W-1:0]   gcnt;
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              pop;
    logic              drop;

    assign pop  = (state == LOAD);
    assign drop = pcm_valid && full && !pop;

    pcm_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pcm_valid),
        .pop   (pop),
        .din   (pcm_in),
        .dout  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    // The MSB goes straight to sdata_out at LOAD, so the shifter only keeps the remaining bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hcnt      <= '0;
            bcnt      <= '0;
            gcnt      <= '0;
            shreg     <= '0;
            sclk_out  <= 1'b0;
            fs_out    <= 1'b0;
            sdata_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg     <= head[DATA_W-2:0];
                    sdata_out <= head[DATA_W-1];
                    fs_out    <= 1'b1;
                    sclk_out  <= 1'b0;
                    hcnt      <= '0;
                    bcnt      <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (hcnt == HC_LAST) begin
                        hcnt     <= '0;
                        sclk_out <= ~sclk_out;
                        if (sclk_out) begin
                            if (bcnt == BC_LAST) begin
                                fs_out    <= 1'b0;
                                sdata_out <= 1'b0;
                                gcnt      <= '0;
                                state     <= GAP;
                            end else begin
                                bcnt      <= bcnt + 1'b1;
                                sdata_out <= shreg[DATA_W-2];
                                shreg     <= {shreg[DATA_W-3:0], 1'b0};
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == GC_LAST) begin
                        state <= IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
        end else if (drop) begin
            ovf_flag <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
        end
    end

endmodule

// File: doc/pcm_serial_tx.md
Name: pcm_serial_tx

Overview:
Output stage placed directly downstream of the decimation chain's 24-bit PCM output register. It accepts 24-bit PCM samples on a single-cycle valid pulse at 1.28 kHz and buffers them in a small synchronous FIFO. It then serialises each sample MSB-first on a master-mode frame/bit-clock/data interface to an external codec or MCU. Overflow is reported through a sticky flag.

Parameters:
DATA_W, 24, sample width in bits.
FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
CLK_DIV, 8, sclk half-period in clk cycles; must be at least 1.
GAP_CYC, 16, minimum number of clk cycles that fs_out stays low between frames; must be at least 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pcm_in  in  DATA_W  PCM sample from the decimator
pcm_valid  in  1  one-cycle strobe qualifying pcm_in
ovf_clr  in  1  synchronous clear of ovf_flag
sclk_out  out  1  serial bit clock; idles low
fs_out  out  1  frame select; high for the whole frame
sdata_out  out  1  serial data, MSB first
ovf_flag  out  1  sticky flag: a sample was dropped
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset state: sclk_out=0, fs_out=0, sdata_out=0, ovf_flag=0, fifo_level=0, FSM=IDLE, FIFO emptied.
- Reset mid-frame: the frame is abandoned immediately and all outputs take their reset values. No partial frame resumes after reset.
- FIFO write: on a cycle with pcm_valid=1, the sample is written if fifo_level<FIFO_DEPTH, or if a pop occurs in the same cycle.
- FIFO overflow: if neither condition holds, the sample is dropped, FIFO contents are unchanged, and ovf_flag is set next cycle.
- ovf_flag: cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- fifo_level: registered. It updates on the edge that performs a push and/or pop; a simultaneous push and pop leaves it unchanged.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE: if fifo_level>0, go to LOAD.
- LOAD (one cycle):
  - pop the FIFO head into the shift register;
  - on exit, fs_out=1 and sdata_out=head[DATA_W-1];
  - the half-period counter and bit counter are cleared;
  - go to SHIFT.
- SHIFT:
  - A half-period counter runs from 0 to CLK_DIV-1; sclk_out toggles each time it wraps.
  - Rising sclk edges are where the receiver samples the data.
  - On each falling sclk edge the shift register shifts left and sdata_out takes the next bit.
  - After the DATA_W-th falling edge, fs_out=0 and sdata_out=0, and the FSM goes to GAP.
  - Frame length is exactly 2*CLK_DIV*DATA_W clk cycles with fs_out high.
- GAP: hold GAP_CYC cycles, then go to IDLE. Back-to-back frames are therefore separated by GAP_CYC + 2 cycles (GAP, IDLE, LOAD).
- Latency: pcm_valid sampled at edge E0 with the FIFO empty and the FSM in IDLE gives fs_out=1 and sdata_out=MSB after edge E2.
- pcm_valid during a frame: the sample is written to the FIFO and never disturbs the frame in progress.
- FIFO pointers: wrap modulo FIFO_DEPTH; ordering is strictly FIFO.
- Data handling: pcm_in is treated as raw bits. There is no sign manipulation or rounding.

Decomposition:
- Shared package pcm_tx_pkg:
  - FSM state enum (IDLE/LOAD/SHIFT/GAP);
  - localparam functions for the fifo_level width and the frame length 2*CLK_DIV*DATA_W.
- One sub-module, pcm_sync_fifo:
  - parameters: width, depth;
  - ports: push, pop, din, dout (head, combinational), level, full, empty;
  - push is accepted when full if pop is asserted in the same cycle.
- The top level holds the FSM, clock divider, shift register and overflow flag.

Test Plan:
1. Single sample: pcm_in=24'hA5F00F, one pulse, CLK_DIV=8. Required: fs_out rises 2 cycles after the strobe edge; 384 cycles high; the 24 bits sampled on sclk rising edges equal A5F00F MSB-first; fs_out low for at least 16 cycles afterwards; fifo_level returns to 0.
2. Burst ordering: 4 strobes, 1 cycle apart, carrying 000001, 800000, 7FFFFF, 123456. Required: fifo_level peaks at 3 (the first sample pops immediately); four frames appear in that order with no ovf_flag.
3. Overflow: 6 strobes, 1 cycle apart, while a frame is in progress. Required: first 4 samples stored; samples 5 and 6 dropped; ovf_flag=1; then ovf_clr pulse gives ovf_flag=0 on the next cycle.
4. Full plus simultaneous pop: FIFO full with the FSM entering LOAD; pcm_valid in the same cycle. Required: sample accepted, fifo_level stays 4, ovf_flag stays 0.
5. Reset mid-frame: assert rst_n=0 at bit 10 of a frame. Required: sclk_out, fs_out, sdata_out, ovf_flag and fifo_level are all 0 asynchronously; after release, no output activity until a new strobe.
6. CLK_DIV=1 corner: one sample 24'hFFFFFF. Required: frame lasts 48 cycles; sclk_out toggles every cycle; sdata_out is held at 1 for all 24 bits.
